leapfrog_step_scheduler: RTL
============================

Name: leapfrog_step_scheduler

Overview:
Sequences kick-drift-kick leapfrog timesteps for NUM_BODIES bodies (one axis) held in internal state registers. A single shared multiply/shift datapath serves all bodies. For each body it requests the acceleration from the external force/acceleration unit over a valid/ready request plus a response strobe. It sits between the host register interface and the acceleration engine, and owns body state during a run.

Parameters:
WIDTH, 64, signed fixed-point word width for pos, vel, accel and dt
FRACTIONAL, 32, fractional bits; products are shifted right arithmetically by FRACTIONAL
NUM_BODIES, 8, number of bodies; must be at least 2
IDX_W, $clog2(NUM_BODIES), body index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins a run; ignored while busy
abort  in  1  single-cycle pulse that stops the run at the next body boundary
num_steps  in  16  timesteps per run; sampled on start
dt  in  WIDTH  Δt; sampled on start
wr_en  in  1  host write of body state; ignored while busy
wr_idx  in  IDX_W  body index for host write
wr_pos  in  WIDTH  position written on wr_en
wr_vel  in  WIDTH  velocity written on wr_en
rd_idx  in  IDX_W  host read index
rd_pos  out  WIDTH  pos[rd_idx], combinational
rd_vel  out  WIDTH  vel[rd_idx], combinational
snap_idx  in  IDX_W  read index for the acceleration unit
snap_pos  out  WIDTH  pos[snap_idx], combinational
acc_req_valid  out  1  acceleration request valid
acc_req_ready  in  1  acceleration unit accepts the request
acc_req_idx  out  IDX_W  body whose acceleration is requested
acc_rsp_valid  in  1  acceleration result strobe
acc_rsp_data  in  WIDTH  acceleration value for the outstanding request
busy  out  1  high from the cycle after start until done or abort completes
done  out  1  one-cycle pulse at normal completion
steps_left  out  16  remaining timesteps

Behaviour:
- Reset (asynchronous, any state): all pos, vel, steps_left and index registers go to 0. busy=0, done=0, acc_req_valid=0, state=IDLE.
- FSM states: IDLE, KICK_REQ, KICK_WAIT, DRIFT, KICK2_REQ, KICK2_WAIT, FINISH.
- IDLE:
  - A host write updates the body at the next edge.
  - On start with num_steps=0: go to FINISH. done pulses the following cycle and no requests are issued.
  - On start with num_steps>0: latch dt and num_steps, set idx=0, go to KICK_REQ.
- KICK_REQ:
  - Assert acc_req_valid with acc_req_idx=idx.
  - Hold valid and idx stable until acc_req_ready; a handshake occurs when both are high.
  - After the handshake go to KICK_WAIT.
- KICK_WAIT:
  - Exactly one request is outstanding at a time.
  - On acc_rsp_valid: vel[idx] <= sat(vel[idx] + ((acc_rsp_data*(dt>>>1))>>>FRACTIONAL)). The product uses the full 2*WIDTH width.
  - Then idx+1 returns to KICK_REQ, or after the last body go to DRIFT with idx=0.
  - The next request is asserted in the cycle after the response.
  - acc_rsp_valid outside a WAIT state is ignored.
- DRIFT: one body per cycle, pos[idx] <= sat(pos[idx] + ((vel[idx]*dt)>>>FRACTIONAL)). The phase is exactly NUM_BODIES cycles, then go to KICK2_REQ with idx=0.
- KICK2_REQ / KICK2_WAIT: same handshake and update as the first kick, using the drifted positions.
- After the last body of the second kick: decrement steps_left. If the result is nonzero, go to KICK_REQ; otherwise go to FINISH.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- sat(): clamp to +2^(WIDTH-1)-1 / -2^(WIDTH-1). It is applied to every vel and pos write. The sum is computed at WIDTH+1 bits so overflow is detectable.
- Position stability: positions are stable throughout both kick phases, so snap_pos stays consistent for the acceleration unit.
- abort:
  - The pulse is latched.
  - In a REQ state before the handshake: drop valid and go to IDLE.
  - In a WAIT state: wait for the response, discard it (no update), then go to IDLE.
  - In DRIFT: finish the current body, then go to IDLE.
  - Body state is retained, done does not pulse, and busy falls on entry to IDLE.
- Simultaneous start and abort in IDLE: abort wins and no run starts.

Optional Feature:
FUSED_KICK_EN:
- Defined:
  - The second kick of step k and the first kick of step k+1 merge into one full kick: vel += (a*dt)>>>FRACTIONAL.
  - Only the first step's opening kick and the final closing kick use dt>>>1.
  - Total requests are NUM_BODIES*(num_steps+1).
  - Results may differ from the unfused form by up to num_steps LSB per velocity, due to rounding.
- Undefined: requests total 2*NUM_BODIES*num_steps, as specified above.

Test Plan:
1. Body0 pos=0, vel=1.0 (0x1_0000_0000), dt=1.0, accel always 0, num_steps=1 -> pos=1.0, vel=1.0, done pulses once, 16 requests with NUM_BODIES=8.
2. Body0 pos=0, vel=0, accel always 2.0, dt=1.0, 1 step -> vel after first kick=1.0, pos=1.0, final vel=2.0.
3. pos=0x7FFF_FFFF_0000_0000, vel=1.0, dt=1.0 -> pos saturates to 0x7FFF_FFFF_FFFF_FFFF, with no wrap.
4. acc_req_ready low for 5 cycles on every request, random response delay 0-7 -> acc_req_idx stable while valid, results identical to a zero-stall run, never more than one request outstanding.
5. num_steps=3, abort pulse in KICK2_WAIT of step 2 -> response consumed, no done, busy low, steps_left=2, state preserved and readable via rd_*.
6. reset_n asserted mid-DRIFT -> outputs and state cleared immediately. num_steps=0 start -> done the next cycle, zero requests. FUSED_KICK_EN build with 8 bodies and 3 steps -> exactly 32 requests.

Source files
------------

// File: rtl/leapfrog_step_scheduler.sv
// Kick-drift-kick leapfrog sequencer for NUM_BODIES bodies on one axis.
// Body state lives here. One shared multiply/shift/saturate datapath serves
// both the velocity kicks and the position drifts. Accelerations come from an
// external unit through a valid/ready request and a response strobe, with at
// most one request outstanding at a time.
//
// Optional build macro FUSED_KICK_EN: merges the closing kick of step k with
// the opening kick of step k+1 into a single full-dt kick. Only the very first
// kick and the very last kick use dt/2. Without the macro, every step issues
// two half-dt kicks.
module leapfrog_step_scheduler #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned FRACTIONAL = 32,
  parameter int unsigned NUM_BODIES = 8,   // at least 2
  parameter int unsigned IDX_W      = $clog2(NUM_BODIES)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [15:0]      num_steps_i,
  input  logic [WIDTH-1:0] dt_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [WIDTH-1:0] wr_pos_i,
  input  logic [WIDTH-1:0] wr_vel_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_pos_o,
  output logic [WIDTH-1:0] rd_vel_o,
  input  logic [IDX_W-1:0] snap_idx_i,
  output logic [WIDTH-1:0] snap_pos_o,
  output logic             acc_req_valid_o,
  input  logic             acc_req_ready_i,
  output logic [IDX_W-1:0] acc_req_idx_o,
  input  logic             acc_rsp_valid_i,
  input  logic [WIDTH-1:0] acc_rsp_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      steps_left_o
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [IDX_W-1:0]        LastIdx = IDX_W'(NUM_BODIES - 1);
  localparam logic signed [WIDTH-1:0] SatMax  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SatMin  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW:0]      SumMax  = (PW+1)'(SatMax);
  localparam logic signed [PW:0]      SumMin  = (PW+1)'(SatMin);

  typedef enum logic [2:0] {
    StIdle,
    StKickReq,
    StKickWait,
    StDrift,
    StKick2Req,
    StKick2Wait,
    StFinish
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic signed [WIDTH-1:0] dt_q;
  logic [15:0]             steps_left_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    req_valid_q;
  logic                    abort_q;

  logic signed [WIDTH-1:0] pos_q [NUM_BODIES];
  logic signed [WIDTH-1:0] vel_q [NUM_BODIES];

  logic                    abort_now;
  logic signed [WIDTH-1:0] half_dt;
  logic signed [WIDTH-1:0] kick_dt;
  logic signed [WIDTH-1:0] mul_a;
  logic signed [WIDTH-1:0] mul_b;
  logic signed [WIDTH-1:0] upd_base;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    term;
  logic signed [PW:0]      sum;
  logic signed [WIDTH-1:0] upd_d;

  // A pending abort is either arriving now or was latched earlier in the run.
  assign abort_now = abort_i | abort_q;

  // Shared datapath: DRIFT computes pos += vel*dt, the kick states vel += a*kdt.
  always_comb begin
    half_dt = dt_q >>> 1;
    kick_dt = half_dt;
`ifdef FUSED_KICK_EN
    // Interior closing kicks also stand in for the next step's opening kick.
    if ((state_q == StKick2Wait) && (steps_left_q != 16'd1)) begin
      kick_dt = dt_q;
    end
`endif
    if (state_q == StDrift) begin
      mul_a    = vel_q[idx_q];
      mul_b    = dt_q;
      upd_base = pos_q[idx_q];
    end else begin
      mul_a    = acc_rsp_data_i;
      mul_b    = kick_dt;
      upd_base = vel_q[idx_q];
    end
    prod = PW'(mul_a) * PW'(mul_b);
    term = prod >>> FRACTIONAL;
    // The sum is kept wide so that an out-of-range product clamps instead of wrapping.
    sum  = (PW+1)'(upd_base) + (PW+1)'(term);
    if (sum > SumMax) begin
      upd_d = SatMax;
    end else if (sum < SumMin) begin
      upd_d = SatMin;
    end else begin
      upd_d = sum[WIDTH-1:0];
    end
  end

  // Sequencer FSM; owns body state, handshake and status registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      dt_q         <= '0;
      steps_left_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      abort_q      <= 1'b0;
      for (int i = 0; i < NUM_BODIES; i++) begin
        pos_q[i] <= '0;
        vel_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (abort_i && busy_q) begin
        abort_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (wr_en_i) begin
            pos_q[wr_idx_i] <= wr_pos_i;
            vel_q[wr_idx_i] <= wr_vel_i;
          end
          // An abort in the same cycle as start suppresses the run.
          if (start_i && !abort_i) begin
            steps_left_q <= num_steps_i;
            dt_q         <= dt_i;
            idx_q        <= '0;
            if (num_steps_i == 16'd0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q     <= StKickReq;
              busy_q      <= 1'b1;
              req_valid_q <= 1'b1;
            end
          end
        end

        StKickReq, StKick2Req: begin
          // A completed handshake takes priority over a same-cycle abort.
          if (acc_req_ready_i) begin
            req_valid_q <= 1'b0;
            state_q     <= (state_q == StKickReq) ? StKickWait : StKick2Wait;
          end else if (abort_now) begin
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
            state_q     <= StIdle;
          end
        end

        StKickWait: begin
          if (acc_rsp_valid_i) begin
            if (abort_now) begin
              // Response is consumed but not applied.
              busy_q  <= 1'b0;
              abort_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              vel_q[idx_q] <= upd_d;
              if (idx_q == LastIdx) begin
                idx_q   <= '0;
                state_q <= StDrift;
              end else begin
                idx_q       <= idx_q + IDX_W'(1);
                req_valid_q <= 1'b1;
                state_q     <= StKickReq;
              end
            end
          end
        end

        StDrift: begin
          pos_q[idx_q] <= upd_d;
          if (abort_now) begin
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            state_q <= StIdle;
          end else if (idx_q == LastIdx) begin
            idx_q       <= '0;
            req_valid_q <= 1'b1;
            state_q     <= StKick2Req;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        StKick2Wait: begin
          if (acc_rsp_valid_i) begin
            if (abort_now) begin
              busy_q  <= 1'b0;
              abort_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              vel_q[idx_q] <= upd_d;
              if (idx_q == LastIdx) begin
                idx_q        <= '0;
                steps_left_q <= steps_left_q - 16'd1;
                if (steps_left_q == 16'd1) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StFinish;
                end else begin
`ifdef FUSED_KICK_EN
                  state_q <= StDrift;
`else
                  req_valid_q <= 1'b1;
                  state_q     <= StKickReq;
`endif
                end
              end else begin
                idx_q       <= idx_q + IDX_W'(1);
                req_valid_q <= 1'b1;
                state_q     <= StKick2Req;
              end
            end
          end
        end

        StFinish: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_pos_o        = pos_q[rd_idx_i];
  assign rd_vel_o        = vel_q[rd_idx_i];
  assign snap_pos_o      = pos_q[snap_idx_i];
  assign acc_req_valid_o = req_valid_q;
  assign acc_req_idx_o   = idx_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign steps_left_o    = steps_left_q;

endmodule
